// File: rtl/reorder_buffer_mw.sv
// Multi-wide reorder buffer: allocates tags at dispatch, captures CDB results,
// retires ready head entries in order and squashes younger entries on flush.
module reorder_buffer_mw #(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned DISPATCH_WIDTH = 2,
  parameter int unsigned RETIRE_WIDTH   = 2,
  parameter int unsigned CDB_PORTS      = 2,
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned REG_BITS       = 5,
  localparam int unsigned TAG_W         = $clog2(DEPTH + 1),
  localparam int unsigned CNT_W         = $clog2(DEPTH + 1)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [DISPATCH_WIDTH-1:0]          dispatch_valid,
  input  logic [DISPATCH_WIDTH*REG_BITS-1:0] dispatch_rd,
  input  logic [DISPATCH_WIDTH-1:0]          dispatch_regwr,
  output logic                               dispatch_ready,
  output logic [DISPATCH_WIDTH*TAG_W-1:0]    dispatch_tag,
  input  logic [CDB_PORTS-1:0]               cdb_valid,
  input  logic [CDB_PORTS*TAG_W-1:0]         cdb_tag,
  input  logic [CDB_PORTS*DATA_WIDTH-1:0]    cdb_value,
  output logic [RETIRE_WIDTH-1:0]            retire_valid,
  output logic [RETIRE_WIDTH*TAG_W-1:0]      retire_tag,
  output logic [RETIRE_WIDTH*REG_BITS-1:0]   retire_rd,
  output logic [RETIRE_WIDTH*DATA_WIDTH-1:0] retire_value,
  output logic [RETIRE_WIDTH-1:0]            retire_regwr,
  input  logic                               flush,
  input  logic [TAG_W-1:0]                   flush_tag,
  output logic [CNT_W-1:0]                   count,
  output logic                               full,
  output logic                               empty
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          D     = int'(DEPTH);

  // Argument must lie in (-DEPTH, 2*DEPTH); DEPTH need not be a power of two.
  function automatic logic [IDX_W-1:0] idx(int v);
    int w;
    w = v;
    if (w >= D) w = w - D;
    else if (w < 0) w = w + D;
    return IDX_W'(w);
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(logic [IDX_W-1:0] s);
    return TAG_W'(s) + TAG_W'(1);
  endfunction

  logic [DEPTH-1:0]      valid_q, valid_d, ready_q, ready_d, regwr_q, regwr_d;
  logic [REG_BITS-1:0]   rd_q    [DEPTH];
  logic [REG_BITS-1:0]   rd_d    [DEPTH];
  logic [DATA_WIDTH-1:0] value_q [DEPTH];
  logic [DATA_WIDTH-1:0] value_d [DEPTH];
  logic [IDX_W-1:0]      head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [IDX_W-1:0]      disp_slot [DISPATCH_WIDTH];
  logic [IDX_W-1:0]      ret_slot  [RETIRE_WIDTH];
  int                    n_disp, n_ret;
  logic                  do_dispatch;

  assign count = count_q;
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  always_comb begin
    n_disp       = 0;
    dispatch_tag = '0;
    for (int i = 0; i < int'(DISPATCH_WIDTH); i++) begin
      disp_slot[i] = idx(int'(tail_q) + n_disp);
      if (dispatch_valid[i]) begin
        dispatch_tag[i*TAG_W +: TAG_W] = tag_of(disp_slot[i]);
        n_disp = n_disp + 1;
      end
    end
    dispatch_ready = (D - int'(count_q)) >= n_disp;
    do_dispatch    = dispatch_ready && (|dispatch_valid) && !flush;
  end

  always_comb begin
    logic chain;
    chain        = 1'b1;
    n_ret        = 0;
    retire_valid = '0;
    retire_tag   = '0;
    retire_rd    = '0;
    retire_value = '0;
    retire_regwr = '0;
    for (int k = 0; k < int'(RETIRE_WIDTH); k++) begin
      ret_slot[k] = idx(int'(head_q) + k);
      chain = chain && (k < int'(count_q)) && valid_q[ret_slot[k]] && ready_q[ret_slot[k]];
      if (chain) begin
        retire_valid[k]                          = 1'b1;
        retire_tag[k*TAG_W +: TAG_W]             = tag_of(ret_slot[k]);
        retire_rd[k*REG_BITS +: REG_BITS]        = rd_q[ret_slot[k]];
        retire_value[k*DATA_WIDTH +: DATA_WIDTH] = value_q[ret_slot[k]];
        retire_regwr[k]                          = regwr_q[ret_slot[k]];
        n_ret = n_ret + 1;
      end
    end
  end

  always_comb begin
    int   fslot, dist_f, kept;
    logic flush_hit;
    valid_d = valid_q;
    ready_d = ready_q;
    regwr_d = regwr_q;
    rd_d    = rd_q;
    value_d = value_q;
    head_d  = idx(int'(head_q) + n_ret);
    tail_d  = tail_q;
    count_d = count_q;

    fslot     = (flush_tag != '0 && int'(flush_tag) <= D) ? int'(flush_tag) - 1 : 0;
    flush_hit = flush && flush_tag != '0 && int'(flush_tag) <= D && valid_q[idx(fslot)];
    dist_f    = int'(idx(fslot - int'(head_q)));
    kept      = dist_f + 1;

    // Walk ports high to low so the lowest-numbered port's write lands last.
    for (int p = int'(CDB_PORTS) - 1; p >= 0; p--) begin
      for (int i = 0; i < D; i++) begin
        if (cdb_valid[p] && int'(cdb_tag[p*TAG_W +: TAG_W]) == i + 1 &&
            valid_q[i] && !ready_q[i]) begin
          ready_d[i] = 1'b1;
          value_d[i] = cdb_value[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end

    for (int k = 0; k < int'(RETIRE_WIDTH); k++) begin
      if (retire_valid[k]) begin
        valid_d[ret_slot[k]] = 1'b0;
        ready_d[ret_slot[k]] = 1'b0;
      end
    end

    if (do_dispatch) begin
      for (int i = 0; i < int'(DISPATCH_WIDTH); i++) begin
        if (dispatch_valid[i]) begin
          valid_d[disp_slot[i]] = 1'b1;
          ready_d[disp_slot[i]] = 1'b0;
          regwr_d[disp_slot[i]] = dispatch_regwr[i];
          rd_d[disp_slot[i]]    = dispatch_rd[i*REG_BITS +: REG_BITS];
        end
      end
    end

    if (flush) begin
      // Squash applied last so it also drops same-cycle CDB writes.
      for (int i = 0; i < D; i++) begin
        if (!flush_hit || int'(idx(i - int'(head_q))) > dist_f) begin
          valid_d[i] = 1'b0;
          ready_d[i] = 1'b0;
        end
      end
      if (flush_hit && kept > n_ret) begin
        tail_d  = idx(fslot + 1);
        count_d = CNT_W'(kept - n_ret);
      end else begin
        tail_d  = head_d;
        count_d = '0;
      end
    end else begin
      if (do_dispatch) tail_d = idx(int'(tail_q) + n_disp);
      count_d = CNT_W'(int'(count_q) + (do_dispatch ? n_disp : 0) - n_ret);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      ready_q <= '0;
      regwr_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < D; i++) begin
        rd_q[i]    <= '0;
        value_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      regwr_q <= regwr_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      value_q <= value_d;
    end
  end

endmodule

// File: doc/reorder_buffer_mw.md
Name: reorder_buffer_mw

Overview:
Parametrised multi-wide reorder buffer: next-generation replacement for the single-dispatch/single-retire ROB logic embedded in the core top level. Sits between dispatch and retire. Allocates tags for up to DISPATCH_WIDTH instructions per cycle and captures results from CDB_PORTS common data buses. Retires up to RETIRE_WIDTH ready head entries in order per cycle, and supports partial squash on branch mispredict.

Parameters:
DEPTH, 16, number of ROB entries; tags are 1..DEPTH and 0 means "no tag"
DISPATCH_WIDTH, 2, dispatch lanes per cycle
RETIRE_WIDTH, 2, retire lanes per cycle
CDB_PORTS, 2, result broadcast ports
DATA_WIDTH, 64, result value width
REG_BITS, 5, architectural register index width
(derived) TAG_W = $clog2(DEPTH+1); CNT_W = $clog2(DEPTH+1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
dispatch_valid  in  DISPATCH_WIDTH  per-lane dispatch request
dispatch_rd  in  DISPATCH_WIDTH*REG_BITS  destination register per lane
dispatch_regwr  in  DISPATCH_WIDTH  lane writes a register
dispatch_ready  out  1  free entries >= popcount(dispatch_valid)
dispatch_tag  out  DISPATCH_WIDTH*TAG_W  tag allocated to each lane; 0 for invalid lanes
cdb_valid  in  CDB_PORTS  broadcast valid
cdb_tag  in  CDB_PORTS*TAG_W  completing tag
cdb_value  in  CDB_PORTS*DATA_WIDTH  result value
retire_valid  out  RETIRE_WIDTH  lane k retires this cycle
retire_tag  out  RETIRE_WIDTH*TAG_W  retiring tag
retire_rd  out  RETIRE_WIDTH*REG_BITS  destination register
retire_value  out  RETIRE_WIDTH*DATA_WIDTH  result value
retire_regwr  out  RETIRE_WIDTH  register write enable (retire_valid & entry regwr)
flush  in  1  squash request
flush_tag  in  TAG_W  youngest surviving tag; 0 squashes everything
count  out  CNT_W  occupied entries, 0..DEPTH
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (reset==0, asynchronous):
  - head = tail = slot 0; count = 0; all entry valid/ready bits cleared.
  - Outputs: empty=1, full=0, dispatch_ready=1, all retire_* = 0, dispatch_tag = 0.
- Entry fields: valid, ready, regwr, rd, value. Tag = slot index + 1 (fixed per slot).
- Dispatch (all-or-nothing):
  - Occurs when dispatch_ready & |dispatch_valid & !flush.
  - Valid lanes are allocated consecutive slots from tail, in ascending lane order; invalid lanes are skipped and consume no slot.
  - dispatch_tag is combinational from the current tail, valid in the same cycle as the request.
  - Allocated entries: valid=1, ready=0. Tail advances by popcount(dispatch_valid) modulo DEPTH.
  - When dispatch_ready=0, nothing is written and the tail is unchanged.
- CDB capture:
  - For each port with cdb_valid and a tag naming a valid, not-ready entry: value <= cdb_value, ready <= 1 at the clock edge.
  - Tag 0, an out-of-range tag, or a tag naming an invalid entry is ignored.
  - Two ports with the same tag: the lowest-numbered port wins.
- Retire (combinational outputs, state update at the edge):
  - retire_valid[k] = 1 iff k < count and entries head..head+k are all valid & ready.
  - At the edge: retired entries are cleared, head advances by the number retired (mod DEPTH).
  - A result captured at edge N is retirable in cycle N+1, i.e. one cycle of CDB-to-retire latency.
  - No back-pressure: retire is unconditional.
- count_next = count + dispatched - retired (a dispatch can land in a slot freed by the same cycle's retire only on the next cycle). dispatch_ready uses the current count.
- Flush:
  - flush_tag != 0: every entry younger than flush_tag is invalidated, and tail <= slot after flush_tag.
  - flush_tag == 0: all entries are invalidated and tail <= head_next.
  - Dispatch is suppressed in a flush cycle. Retire in the same cycle still proceeds.
  - count_next = (tail_next - head_next) mod DEPTH, or DEPTH when flush_tag is the entry just before head_next and the buffer stays full.
  - CDB writes to squashed entries in the flush cycle are discarded.
  - flush_tag naming an invalid entry is treated as flush_tag == 0.
- Wrap-around: all pointer arithmetic is modulo DEPTH. DEPTH need not be a power of two.
- Reset asserted mid-operation clears all state immediately; no pending retire is emitted.

Test Plan:
- DEPTH=8, DW=2: dispatch 2/cycle for 4 cycles → tags 1,2 / 3,4 / 5,6 / 7,8, then full=1, count=8, dispatch_ready=0; a 5th request is not accepted and the tail is unchanged.
- dispatch_valid=2'b10 on an empty ROB → dispatch_tag lane0=0, lane1=1; count=1.
- Entries 1..3 allocated; CDB completes tag 2 then tag 1 → no retire until tag 1 is ready; the cycle after tag 1 is captured, retire_valid=2'b11 with tags 1,2, head moves to slot 2, count=1.
- Both CDB ports carry tag 3 with values 0xAA and 0xBB → entry 3 value = 0xAA.
- Tags 1..6 valid, flush with flush_tag=3 and concurrent dispatch → count=3, next dispatch receives tag 4, the concurrent dispatch is dropped; a later CDB for tag 5 is ignored.
- Wrap: head at slot 6 with DEPTH=8; retire tags 7,8 and dispatch 2 lanes → tags 1,2 allocated, retire tags are 7 then 8; reset driven low mid-stream → count=0, empty=1 asynchronously.
